// File: rtl/flash_cmd_responder.sv
// flash_cmd_responder
// Device-side model of a 16-bit parallel NOR flash. It decodes JEDEC
// unlock/command write cycles (word program, chip erase, sector erase,
// reset), holds a small word array, drives ready/busy and returns array
// data on reads.
// Build option FLASH_RESP_STATUS_EN: when defined, reads issued during a
// program/erase return DQ7/DQ6 status instead of 16'hFFFF.
//
// state | meaning
// IDLE  | ready, waiting for AA@555
// U1    | first unlock seen, waiting for 55@2AA
// U2    | unlocked, waiting for A0@555 (program) or 80@555 (erase)
// PARM  | next write supplies program address/data
// E0    | erase setup, waiting for AA@555
// E1    | erase second unlock, waiting for 55@2AA
// E2    | waiting for 10@555 (chip) or 30@sector (sector)
// PBUSY | word program in progress
// EBUSY | erase in progress (one word per cycle, then extra wait)

module flash_cmd_responder #(
    parameter int MEM_AW      = 8,
    parameter int SECTOR_AW   = 6,
    parameter int PROG_CYCLES = 16,
    parameter int ERASE_EXTRA = 32
) (
    input  logic        CLK50M,
    input  logic        flash_rst_n,
    input  logic        flash_ce_n,
    input  logic        flash_oe_n,
    input  logic        flash_we_n,
    input  logic [21:0] flash_addr,
    input  logic [15:0] flash_dq_i,
    output logic [15:0] flash_dq_o,
    output logic        flash_dq_oe,
    output logic        flash_ready,
    output logic        cmd_err
);

    localparam int CHIP_WORDS = 1 << MEM_AW;
    localparam int SECT_WORDS = 1 << SECTOR_AW;
    localparam int ERW        = MEM_AW + 1;

    localparam logic [15:0]    PROG_LOAD = 16'(PROG_CYCLES - 1);
    localparam logic [15:0]    CHIP_LOAD = 16'(CHIP_WORDS + ERASE_EXTRA - 1);
    localparam logic [15:0]    SECT_LOAD = 16'(SECT_WORDS + ERASE_EXTRA - 1);
    localparam logic [ERW-1:0] CHIP_CNT  = ERW'(CHIP_WORDS);
    localparam logic [ERW-1:0] SECT_CNT  = ERW'(SECT_WORDS);

    typedef enum logic [3:0] {
        ST_IDLE, ST_U1, ST_U2, ST_PARM, ST_E0, ST_E1, ST_E2, ST_PBUSY, ST_EBUSY
    } state_t;

    state_t state;

    // S1 pin samples (_s) and the sample before them (_p)
    logic        ce_s, oe_s, we_s, ce_p, oe_p, we_p;
    logic [21:0] addr_s, addr_p;
    logic [15:0] dq_s, dq_p;

    logic [15:0]       busy_cnt;
    logic [MEM_AW-1:0] prog_addr;
    logic [15:0]       prog_data;
    logic              prog_pend;
    logic [MEM_AW-1:0] er_ptr;
    logic [ERW-1:0]    er_rem;

    logic [15:0] mem [CHIP_WORDS];

    logic       wr_stb, rd_act, busy, at_555, at_2aa, bad_is_err;
    logic [7:0] wr_byte;
    logic [15:0] busy_word;
    logic       unused_bits;

    assign wr_stb     = !ce_p && !we_p && we_s;
    assign wr_byte    = dq_p[7:0];
    assign at_555     = addr_p[10:0] == 11'h555;
    assign at_2aa     = addr_p[10:0] == 11'h2AA;
    assign bad_is_err = wr_byte != 8'hF0;
    assign rd_act     = !ce_s && !oe_s && we_s;
    assign busy       = (state == ST_PBUSY) || (state == ST_EBUSY);
    assign unused_bits = ^{addr_p[21:11], oe_p};

`ifdef FLASH_RESP_STATUS_EN
    logic rd_tog, rd_start, rd_tog_nxt;
    assign rd_start   = !ce_s && !oe_s && oe_p;
    assign rd_tog_nxt = rd_tog ^ rd_start;
    // erase reports DQ7 = 0; program reports the complement of its data bit 7
    assign busy_word  = {8'h00, (state == ST_PBUSY) ? ~prog_data[7] : 1'b0,
                         rd_tog_nxt, 6'b00_0000};
`else
    assign busy_word  = 16'hFFFF;
`endif

    // Register the bus pins once, and keep the previous sample for edge detection
    always_ff @(posedge CLK50M or negedge flash_rst_n) begin
        if (!flash_rst_n) begin
            ce_s   <= 1'b1;
            oe_s   <= 1'b1;
            we_s   <= 1'b1;
            addr_s <= '0;
            dq_s   <= '0;
            ce_p   <= 1'b1;
            oe_p   <= 1'b1;
            we_p   <= 1'b1;
            addr_p <= '0;
            dq_p   <= '0;
        end else begin
            ce_s   <= flash_ce_n;
            oe_s   <= flash_oe_n;
            we_s   <= flash_we_n;
            addr_s <= flash_addr;
            dq_s   <= flash_dq_i;
            ce_p   <= ce_s;
            oe_p   <= oe_s;
            we_p   <= we_s;
            addr_p <= addr_s;
            dq_p   <= dq_s;
        end
    end

    // Command sequencer, busy timer and erase walker
    always_ff @(posedge CLK50M or negedge flash_rst_n) begin
        if (!flash_rst_n) begin
            state       <= ST_IDLE;
            busy_cnt    <= '0;
            prog_addr   <= '0;
            prog_data   <= '0;
            prog_pend   <= 1'b0;
            er_ptr      <= '0;
            er_rem      <= '0;
            flash_ready <= 1'b1;
            cmd_err     <= 1'b0;
        end else begin
            cmd_err   <= 1'b0;
            prog_pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_stb) begin
                        if (at_555 && wr_byte == 8'hAA) state <= ST_U1;
                        else cmd_err <= bad_is_err;
                    end
                end
                ST_U1, ST_E1: begin
                    if (wr_stb) begin
                        if (at_2aa && wr_byte == 8'h55) begin
                            state <= (state == ST_U1) ? ST_U2 : ST_E2;
                        end else begin
                            state   <= ST_IDLE;
                            cmd_err <= bad_is_err;
                        end
                    end
                end
                ST_U2: begin
                    if (wr_stb) begin
                        if (at_555 && wr_byte == 8'hA0) state <= ST_PARM;
                        else if (at_555 && wr_byte == 8'h80) state <= ST_E0;
                        else begin
                            state   <= ST_IDLE;
                            cmd_err <= bad_is_err;
                        end
                    end
                end
                ST_PARM: begin
                    if (wr_stb) begin
                        prog_addr   <= addr_p[MEM_AW-1:0];
                        prog_data   <= dq_p;
                        prog_pend   <= 1'b1;
                        busy_cnt    <= PROG_LOAD;
                        flash_ready <= 1'b0;
                        state       <= ST_PBUSY;
                    end
                end
                ST_E0: begin
                    if (wr_stb) begin
                        if (at_555 && wr_byte == 8'hAA) state <= ST_E1;
                        else begin
                            state   <= ST_IDLE;
                            cmd_err <= bad_is_err;
                        end
                    end
                end
                ST_E2: begin
                    if (wr_stb) begin
                        if (at_555 && wr_byte == 8'h10) begin
                            er_ptr      <= '0;
                            er_rem      <= CHIP_CNT;
                            busy_cnt    <= CHIP_LOAD;
                            flash_ready <= 1'b0;
                            state       <= ST_EBUSY;
                        end else if (wr_byte == 8'h30) begin
                            er_ptr      <= {addr_p[MEM_AW-1:SECTOR_AW], {SECTOR_AW{1'b0}}};
                            er_rem      <= SECT_CNT;
                            busy_cnt    <= SECT_LOAD;
                            flash_ready <= 1'b0;
                            state       <= ST_EBUSY;
                        end else begin
                            state   <= ST_IDLE;
                            cmd_err <= bad_is_err;
                        end
                    end
                end
                ST_PBUSY, ST_EBUSY: begin
                    if (state == ST_EBUSY && er_rem != '0) begin
                        er_ptr <= er_ptr + 1'b1;
                        er_rem <= er_rem - ERW'(1);
                    end
                    if (busy_cnt == 16'd0) begin
                        state       <= ST_IDLE;
                        flash_ready <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt - 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Array writes: program ANDs in its data once, erase fills one word per cycle
    always_ff @(posedge CLK50M) begin
        if (prog_pend) mem[prog_addr] <= mem[prog_addr] & prog_data;
        else if (state == ST_EBUSY && er_rem != '0) mem[er_ptr] <= 16'hFFFF;
    end

    // Read path: drive data one edge after the S1 read sample, hold otherwise
    always_ff @(posedge CLK50M or negedge flash_rst_n) begin
        if (!flash_rst_n) begin
            flash_dq_o  <= 16'h0000;
            flash_dq_oe <= 1'b0;
`ifdef FLASH_RESP_STATUS_EN
            rd_tog      <= 1'b0;
`endif
        end else begin
`ifdef FLASH_RESP_STATUS_EN
            rd_tog <= rd_tog_nxt;
`endif
            flash_dq_oe <= rd_act;
            if (rd_act) flash_dq_o <= busy ? busy_word : mem[addr_s[MEM_AW-1:0]];
        end
    end

endmodule

// File: tb/tb_flash_cmd_responder.sv
// tb_flash_cmd_responder: randomized command/read traffic against a
// word-array reference model; reads are scored by a separate monitor.
`timescale 1ns/1ps
module tb_flash_cmd_responder;

    localparam int MEM_AW      = 8;
    localparam int SECTOR_AW   = 6;
    localparam int PROG_CYCLES = 16;
    localparam int ERASE_EXTRA = 32;
    localparam int CHIP_BUSY   = (1 << MEM_AW) + ERASE_EXTRA;
    localparam int SECT_BUSY   = (1 << SECTOR_AW) + ERASE_EXTRA;

    logic        CLK50M = 1'b0;
    logic        flash_rst_n = 1'b0;
    logic        flash_ce_n = 1'b1;
    logic        flash_oe_n = 1'b1;
    logic        flash_we_n = 1'b1;
    logic [21:0] flash_addr = '0;
    logic [15:0] flash_dq_i = '0;
    logic [15:0] flash_dq_o;
    logic        flash_dq_oe;
    logic        flash_ready;
    logic        cmd_err;

    always #5 CLK50M = ~CLK50M;

    flash_cmd_responder #(
        .MEM_AW(MEM_AW), .SECTOR_AW(SECTOR_AW),
        .PROG_CYCLES(PROG_CYCLES), .ERASE_EXTRA(ERASE_EXTRA)
    ) dut (
        .CLK50M(CLK50M), .flash_rst_n(flash_rst_n),
        .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n),
        .flash_addr(flash_addr), .flash_dq_i(flash_dq_i),
        .flash_dq_o(flash_dq_o), .flash_dq_oe(flash_dq_oe),
        .flash_ready(flash_ready), .cmd_err(cmd_err)
    );

    typedef struct {
        logic [21:0] addr;
        logic [15:0] data;
    } rd_exp_t;

    rd_exp_t     exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          err_seen = 0;
    int          err_exp = 0;
    int          rd_cnt = 0;
    logic        err_prev = 1'b0;
    logic [15:0] last_rd = 16'h0000;
    logic [15:0] mdl [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: score every presented read, track cmd_err pulses
    always @(posedge CLK50M) begin
        rd_exp_t e;
        #1;
        if (flash_dq_oe) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_read: got 0x%0h with no read pending", flash_dq_o);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("read@%0h", e.addr), {16'h0, flash_dq_o}, {16'h0, e.data});
            end
        end
        if (cmd_err) begin
            err_seen++;
            check("cmd_err_width", {31'h0, err_prev}, 32'h0);
        end
        err_prev = cmd_err;
    end

    task automatic bus_write(input logic [21:0] a, input logic [15:0] d);
        @(negedge CLK50M);
        flash_ce_n = 1'b0; flash_we_n = 1'b0; flash_addr = a; flash_dq_i = d;
        @(negedge CLK50M);
        flash_we_n = 1'b1;
        @(negedge CLK50M);
        flash_ce_n = 1'b1;
        flash_dq_i = 16'($urandom);
    endtask

    // command cycle with random don't-care upper address/data bits
    task automatic cmd(input logic [10:0] a, input logic [7:0] b);
        bus_write({11'($urandom), a}, {8'($urandom), b});
    endtask

    task automatic read_exp(input logic [21:0] a, input logic [15:0] d);
        rd_exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        last_rd = d;
        @(negedge CLK50M);
        flash_ce_n = 1'b0; flash_oe_n = 1'b0; flash_addr = a;
        @(negedge CLK50M);
        flash_ce_n = 1'b1; flash_oe_n = 1'b1;
        rd_cnt++;
    endtask

    task automatic read_mem(input logic [7:0] a);
        read_exp({14'($urandom), a}, mdl[a]);
    endtask

    task automatic wait_fall(input string name, output bit seen);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK50M);
            if (!flash_ready) begin
                seen = 1;
                break;
            end
        end
        check({name, "_ready_fall"}, {31'h0, seen}, 32'h1);
    endtask

    task automatic wait_busy(input string name, input int cycles);
        bit seen;
        int n;
        wait_fall(name, seen);
        if (seen) begin
            n = 1;
            while (!flash_ready && n < 1000) begin
                @(negedge CLK50M);
                if (!flash_ready) n++;
            end
            check({name, "_busy_cycles"}, n, cycles);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!flash_ready && n < 200) begin
            @(negedge CLK50M);
            n++;
        end
        check({name, "_back_to_ready"}, {31'h0, flash_ready}, 32'h1);
    endtask

    task automatic check_errs(input string name);
        repeat (3) @(negedge CLK50M);
        check(name, err_seen, err_exp);
    endtask

    task automatic program_word(input logic [7:0] a, input logic [15:0] d);
        cmd(11'h555, 8'hAA); cmd(11'h2AA, 8'h55); cmd(11'h555, 8'hA0);
        bus_write({14'($urandom), a}, d);
        mdl[a] = mdl[a] & d;
        wait_busy("program", PROG_CYCLES);
    endtask

    task automatic erase_cmds(input logic [10:0] a, input logic [7:0] b);
        cmd(11'h555, 8'hAA); cmd(11'h2AA, 8'h55); cmd(11'h555, 8'h80);
        cmd(11'h555, 8'hAA); cmd(11'h2AA, 8'h55);
        bus_write({11'($urandom), a}, {8'($urandom), b});
    endtask

    task automatic chip_erase();
        erase_cmds(11'h555, 8'h10);
        for (int i = 0; i < 256; i++) mdl[i] = 16'hFFFF;
        wait_busy("chip_erase", CHIP_BUSY);
    endtask

    task automatic sector_erase(input logic [7:0] a);
        int base;
        erase_cmds({3'($urandom), a}, 8'h30);
        base = int'(a) & 8'hC0;
        for (int i = 0; i < 64; i++) mdl[base + i] = 16'hFFFF;
        wait_busy("sector_erase", SECT_BUSY);
    endtask

    function automatic logic [15:0] busy_read_val(input logic [15:0] d);
`ifdef FLASH_RESP_STATUS_EN
        logic tog;
        tog = ((rd_cnt + 1) % 2) == 1;
        return {8'h00, ~d[7], tog, 6'b00_0000};
`else
        return 16'hFFFF;
`endif
    endfunction

    // program, read status twice while busy, and poke writes that must be ignored
    task automatic program_busy_probe(input logic [7:0] a, input logic [15:0] d);
        bit seen;
        cmd(11'h555, 8'hAA); cmd(11'h2AA, 8'h55); cmd(11'h555, 8'hA0);
        bus_write({14'($urandom), a}, d);
        mdl[a] = mdl[a] & d;
        wait_fall("probe", seen);
        if (seen) begin
            read_exp({14'h0, a}, busy_read_val(d));
            read_exp({14'h0, a}, busy_read_val(d));
            cmd(11'h000, 8'hF0);
            cmd(11'h123, 8'h77);
            wait_idle("probe");
        end
        check_errs("busy_writes_no_err");
        read_mem(a);
    endtask

    task automatic bad_sequence();
        logic [7:0] b;
        case ($urandom_range(0, 2))
            0: begin
                b = 8'($urandom);
                if (b == 8'hAA || b == 8'hF0) b = 8'h5A;
                cmd(11'($urandom), b);
            end
            1: begin
                cmd(11'h555, 8'hAA);
                cmd(11'h2AB + 11'($urandom_range(0, 100)), 8'h55);
            end
            default: begin
                cmd(11'h555, 8'hAA); cmd(11'h2AA, 8'h55); cmd(11'h555, 8'h80);
                cmd(11'h555, 8'hAA); cmd(11'h555, 8'h77);
            end
        endcase
        err_exp++;
        check_errs("bad_seq_err_count");
    endtask

    task automatic abort_sequence();
        int depth = $urandom_range(0, 4);
        if (depth >= 1) cmd(11'h555, 8'hAA);
        if (depth >= 2) cmd(11'h2AA, 8'h55);
        if (depth >= 3) cmd(11'h555, 8'h80);
        if (depth >= 4) cmd(11'h555, 8'hAA);
        cmd(11'($urandom), 8'hF0);
        check_errs("abort_no_err");
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) mdl[i] = 16'h0000;

        repeat (3) @(negedge CLK50M);
        check("rst_ready", {31'h0, flash_ready}, 32'h1);
        check("rst_dq_oe", {31'h0, flash_dq_oe}, 32'h0);
        check("rst_cmd_err", {31'h0, cmd_err}, 32'h0);
        check("rst_dq_o", {16'h0, flash_dq_o}, 32'h0);
        flash_rst_n = 1'b1;
        repeat (2) @(negedge CLK50M);

        chip_erase();
        read_mem(8'h00); read_mem(8'h7F); read_mem(8'hFF);

        program_word(8'h40, 16'h1234);
        read_mem(8'h40);
        check("model_1234", {16'h0, mdl[8'h40]}, 32'h1234);
        program_word(8'h40, 16'hFF00);
        read_mem(8'h40);
        program_word(8'h80, 16'hA5C3);
        sector_erase(8'h45);
        read_mem(8'h40); read_mem(8'h7F); read_mem(8'h80); read_mem(8'h3F);

        cmd(11'h555, 8'hAA); cmd(11'h2AA, 8'h55); cmd(11'h000, 8'hF0);
        check_errs("f0_abort_no_err");
        cmd(11'h555, 8'hAA); cmd(11'h2AA, 8'h12);
        err_exp++;
        check_errs("bad_unlock_err");
        program_word(8'h10, 16'h0F0F);
        read_mem(8'h10);

        program_busy_probe(8'h22, 16'h0080);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 6))
                0, 1: program_word(8'($urandom), 16'($urandom));
                2:    begin read_mem(8'($urandom)); read_mem(8'($urandom)); end
                3:    bad_sequence();
                4:    abort_sequence();
                5:    sector_erase(8'($urandom));
                default: program_busy_probe(8'($urandom), 16'($urandom));
            endcase
        end

        // reset ten cycles into a chip erase
        program_word(8'd5, 16'($urandom) & 16'h7FFF);
        program_word(8'd10, 16'($urandom) & 16'h7FFF);
        program_word(8'd11, 16'($urandom) & 16'h7FFF);
        erase_cmds(11'h555, 8'h10);
        wait_fall("reset_erase", seen);
        if (seen) begin
            repeat (10) @(posedge CLK50M);
            #2 flash_rst_n = 1'b0;
            #1;
            check("mid_erase_rst_ready", {31'h0, flash_ready}, 32'h1);
            check("mid_erase_rst_dq_oe", {31'h0, flash_dq_oe}, 32'h0);
            for (int i = 0; i < 10; i++) mdl[i] = 16'hFFFF;
            repeat (2) @(negedge CLK50M);
            rd_cnt = 0;
            flash_rst_n = 1'b1;
            @(negedge CLK50M);
        end
        for (int i = 0; i < 12; i++) read_mem(8'(i));
        read_mem(8'hC8);

        repeat (6) @(negedge CLK50M);
        check("dq_o_holds", {16'h0, flash_dq_o}, {16'h0, last_rd});
        check("dq_oe_idle", {31'h0, flash_dq_oe}, 32'h0);
        check("exp_queue_drained", exp_q.size(), 0);
        check("final_err_count", err_seen, err_exp);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

endmodule
